// File: rtl/aes_pkg.sv
// Shared AES definitions: controller FSM encoding, round count, round-index width, block type.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam int AES_NR = 10;
    localparam int RND_W  = 4;

    typedef logic [127:0] block_t;

endpackage

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 sequencer: initial AddRoundKey, then steps an external round datapath through rounds 1..NR.
// Optional feature: AES_CTRL_ABORT_EN adds an ABORT input that discards the block in flight.
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [127:0]       IN_DATA,
    output logic [RND_W-1:0]   RK_IDX,
    input  logic [127:0]       RK_DATA,
    output logic [127:0]       RND_STATE_OUT,
    output logic               RND_FINAL,
    input  logic [127:0]       RND_STATE_IN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [127:0]       OUT_DATA,
`ifdef AES_CTRL_ABORT_EN
    input  logic               ABORT,
`endif
    output fsm_t               fsm_state
);

    localparam logic [RND_W-1:0] LAST = RND_W'(NR);

    fsm_t                fsm;
    block_t              state;
    logic [RND_W-1:0]    rnd;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Ready/valid are decoded from the FSM register only, so neither depends on the peer's signal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm   <= IDLE;
            state <= '0;
            rnd   <= '0;
        end else begin
`ifdef AES_CTRL_ABORT_EN
            if (ABORT && (fsm != IDLE)) begin
                fsm   <= IDLE;
                state <= '0;
                rnd   <= '0;
            end else
`endif
            begin
                case (fsm)
                    IDLE: begin
                        if (IN_VALID) begin
                            state <= IN_DATA ^ RK_DATA;
                            rnd   <= RND_W'(1);
                            fsm   <= ROUND;
                        end
                    end
                    ROUND: begin
                        state <= RND_STATE_IN;
                        if (rnd == LAST) begin
                            fsm <= DONE;
                        end else begin
                            rnd <= rnd + 1'b1;
                        end
                    end
                    DONE: begin
                        // Returning to IDLE first keeps the accept one cycle after the output transfer.
                        if (OUT_READY) begin
                            fsm <= IDLE;
                            rnd <= '0;
                        end
                    end
                    default: begin
                        fsm <= IDLE;
                    end
                endcase
            end
        end
    end

    assign IN_READY      = (fsm == IDLE);
    assign OUT_VALID     = (fsm == DONE);
    assign RK_IDX        = (fsm == ROUND) ? rnd : '0;
    assign RND_FINAL     = (fsm == ROUND) && (rnd == LAST);
    assign RND_STATE_OUT = state;
    assign OUT_DATA      = state;
    assign fsm_state     = fsm;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl with a behavioural AES round datapath and key schedule.
module tb_aes128_round_ctrl;
    import aes_pkg::*;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALT_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;
    logic [127:0] rnd_state_out;
    logic         rnd_final;
    logic [127:0] rnd_state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         abort;
    fsm_t         dbg_state;

    int checks;
    int errors;

    logic [127:0] rk_tab [0:10];

    aes128_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .IN_VALID     (in_valid),
        .IN_READY     (in_ready),
        .IN_DATA      (in_data),
        .RK_IDX       (rk_idx),
        .RK_DATA      (rk_data),
        .RND_STATE_OUT(rnd_state_out),
        .RND_FINAL    (rnd_final),
        .RND_STATE_IN (rnd_state_in),
        .OUT_VALID    (out_valid),
        .OUT_READY    (out_ready),
        .OUT_DATA     (out_data),
`ifdef AES_CTRL_ABORT_EN
        .ABORT        (abort),
`endif
        .fsm_state    (dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // golden GF(2^8) / AES round model
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = xtime(aa);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] p;
        inv = 8'h01;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, p);
            p = gmul(p, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = s[4*((c+r)%4)+r];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] st;
        st = pt ^ rk_tab[0];
        for (int r = 1; r <= 10; r++) st = aes_round(st, rk_tab[r], r == 10);
        return st;
    endfunction

    task automatic init_keys(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // external key schedule and round datapath, both combinational
    always_comb begin
        rk_data = 128'h0;
        if (rk_idx <= 4'd10) rk_data = rk_tab[rk_idx];
    end

    always_comb begin
        rnd_state_in = aes_round(rnd_state_out, rk_data, rnd_final);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got %0d exp 0", rk_idx); end
        checks++; if (rnd_final !== 1'b0) begin errors++; $display("FAIL reset_rnd_final got %b exp 0", rnd_final); end
        checks++; if (rnd_state_out !== 128'h0) begin errors++; $display("FAIL reset_state got %h exp 0", rnd_state_out); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_fips();
        logic exp_final;
        in_data  = FIPS_PT;
        in_valid = 1'b1;
        #1;
        checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL fips_accept_rk_idx got %0d exp 0", rk_idx); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_accept_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        for (int k = 1; k <= 10; k++) begin
            exp_final = (k == 10);
            checks++; if (rk_idx !== 4'(k)) begin errors++; $display("FAIL fips_rk_idx cycle %0d got %0d exp %0d", k, rk_idx, k); end
            checks++; if (rnd_final !== exp_final) begin errors++; $display("FAIL fips_rnd_final cycle %0d got %b exp %b", k, rnd_final, exp_final); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_early_valid cycle %0d got %b exp 0", k, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fips_busy_ready cycle %0d got %b exp 0", k, in_ready); end
            tick();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fips_out_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== FIPS_CT) begin errors++; $display("FAIL fips_out_data got %h exp %h", out_data, FIPS_CT); end
        checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL fips_done_rk_idx got %0d exp 0", rk_idx); end
        checks++; if (rnd_final !== 1'b0) begin errors++; $display("FAIL fips_done_final got %b exp 0", rnd_final); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_valid_drop got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_ready_return got %b exp 1", in_ready); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data   = FIPS_PT;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        in_valid = 1'b1;
        in_data  = ALT_PT;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cycle %0d got %b exp 1", i, out_valid); end
            checks++; if (out_data !== FIPS_CT) begin errors++; $display("FAIL bp_data cycle %0d got %h exp %h", i, out_data, FIPS_CT); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", i, in_ready); end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got %b exp 1", out_valid); end
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int           acc_cyc [2];
        logic [127:0] got [2];
        logic [127:0] exp_alt;
        int           n_acc;
        int           n_out;
        n_acc     = 0;
        n_out     = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        got[0]    = 128'h0;
        got[1]    = 128'h0;
        exp_alt   = aes_ref(ALT_PT);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 40 && n_out < 2; cyc++) begin
            in_data = (n_acc == 0) ? FIPS_PT : ALT_PT;
            #1;
            if (in_ready && in_valid && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                got[n_out] = out_data;
                n_out++;
                if (n_out == 2) in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (n_out !== 2) begin errors++; $display("FAIL b2b_outputs got %0d exp 2", n_out); end
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", n_acc); end
        checks++; if (acc_cyc[1] - acc_cyc[0] !== 12) begin errors++; $display("FAIL b2b_period got %0d exp 12", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (got[0] !== FIPS_CT) begin errors++; $display("FAIL b2b_first got %h exp %h", got[0], FIPS_CT); end
        checks++; if (got[1] !== exp_alt) begin errors++; $display("FAIL b2b_second got %h exp %h", got[1], exp_alt); end
    endtask

    task automatic test_reset_mid();
        logic         hit;
        logic [127:0] exp_alt;
        exp_alt  = aes_ref(ALT_PT);
        hit      = 1'b0;
        in_data  = FIPS_PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (rk_idx == 4'd5) hit = 1'b1;
            else tick();
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rmid_reach_round5 got %b exp 1", hit); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
        checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL rmid_rk_idx got %0d exp 0", rk_idx); end
        checks++; if (rnd_final !== 1'b0) begin errors++; $display("FAIL rmid_final got %b exp 0", rnd_final); end
        checks++; if (rnd_state_out !== 128'h0) begin errors++; $display("FAIL rmid_state got %h exp 0", rnd_state_out); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rmid_out_data got %h exp 0", out_data); end
        rst = 1'b0;
        tick();
        in_data  = ALT_PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_next_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== exp_alt) begin errors++; $display("FAIL rmid_next_data got %h exp %h", out_data, exp_alt); end
        tick();
    endtask

`ifdef AES_CTRL_ABORT_EN
    task automatic test_abort();
        logic hit;
        int   seen;
        hit      = 1'b0;
        seen     = 0;
        in_data  = ALT_PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            if (rk_idx == 4'd3) hit = 1'b1;
            else tick();
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach_round3 got %b exp 1", hit); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b exp 0", out_valid); end
        checks++; if (rnd_state_out !== 128'h0) begin errors++; $display("FAIL abort_state got %h exp 0", rnd_state_out); end
        checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL abort_rk_idx got %0d exp 0", rk_idx); end
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_output got %0d exp 0", seen); end
        in_data  = FIPS_PT;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_next_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== FIPS_CT) begin errors++; $display("FAIL abort_next_data got %h exp %h", out_data, FIPS_CT); end
        tick();
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 128'h0;
        out_ready = 1'b1;
        abort     = 1'b0;
        init_keys(FIPS_KEY);
        test_reset();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_CTRL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
